inta_sequencer: RTL
===================

// Module: inta_sequencer
// PURPOSE
//  Synchronous interrupt-acknowledge controller for the 8259A-style PIC. Sits between the
//  IRR block and the CPU bus interface. Resolves priority over unmasked pending requests,
//  raises INT, and sequences the two-pulse INTA handshake: freeze IRR, set ISR, clear the
//  IRR bit, drive the vector. Owns the ISR and services EOI commands from control logic.
// PARAMETERS
//  NUM_IRQ  8  request lines; a power of 2, at most 8; the ISR index width is $clog2(NUM_IRQ)
//  SYNC_STG 2  synchronizer flops on inta_n_i
// PORTS
//  clk           in  1        system clock; all state on rising edge
//  rst_n         in  1        asynchronous active-low reset
//  irr_i         in  NUM_IRQ  pending requests from IRR (IRR_priority)
//  imr_i         in  NUM_IRQ  mask register; 1 = masked
//  vec_base_i    in  5        ICW2 T7..T3
//  aeoi_i        in  1        automatic EOI mode
//  rot_aeoi_i    in  1        rotate priority on AEOI
//  eoi_vld_i     in  1        one-cycle EOI command strobe
//  eoi_spec_i    in  1        1 = specific EOI, 0 = non-specific
//  eoi_rot_i     in  1        rotate priority on this EOI
//  eoi_lvl_i     in  3        level for a specific EOI
//  inta_n_i      in  1        CPU INTA, asynchronous, active-low
//  int_o         out 1        interrupt to CPU
//  inta_freeze_o out 1        freeze to IRR (INTA_FREEZE)
//  irr_clr_o     out NUM_IRQ  one-hot clear to IRR (INTA_1), valid 1 cycle
//  isr_o         out NUM_IRQ  in-service register
//  vec_o         out 8        {vec_base_i, level[2:0]}
//  vec_oe_o      out 1        vec_o valid for the data-bus driver
// BEHAVIOUR
//  Reset (async): all outputs 0; state IDLE; lowest-priority pointer = NUM_IRQ-1 (IR0 highest).
//  inta_n_i passes through SYNC_STG flops. fall = sampled 1->0 edge; rise = sampled 0->1 edge.
//  Priority: candidates = irr_i & ~imr_i. Scan starts at (ptr+1) mod NUM_IRQ and wraps
//    around. Winner is valid only if it ranks above the highest-ranked set ISR bit
//    (fully nested). win_vld and win_lvl are combinational.
//  FSM:
//   IDLE : win_vld -> REQ; int_o<=1 on the next cycle (1-cycle latency).
//   REQ  : fall -> ACK1. Idle while inta_n stays high. int_o stays 1 if win_vld drops
//          (spurious: handled in ACK1).
//   ACK1 : (single cycle) inta_freeze_o<=1; latch lvl=win_lvl; set isr[lvl]; pulse
//          irr_clr_o[lvl]; int_o<=0. If no winner: lvl=7, no ISR set, no clear (spurious
//          IR7 per 8259A). -> WAIT1.
//   WAIT1: rise -> WAIT2.  WAIT2: fall -> ACK2.
//   ACK2 : vec_o={vec_base_i,lvl}; vec_oe_o=1 while inta_n low. On rise: vec_oe_o<=0 and
//          inta_freeze_o<=0. If aeoi_i, clear isr[lvl]. If aeoi_i && rot_aeoi_i,
//          ptr<=lvl. -> IDLE.
//  EOI (any state, applied the cycle after the strobe):
//   non-specific clears the highest-ranked set ISR bit.
//   specific clears isr[eoi_lvl_i].
//   eoi_rot_i sets ptr to the cleared level.
//   EOI with ISR empty: no-op.
//  Simultaneous EOI and ISR set in ACK1 at the same bit: the set wins. Different bits:
//   both are applied.
//  inta_freeze_o is high from ACK1 through the end of ACK2. irr_clr_o is high for
//   exactly 1 cycle per acknowledge.
//  rst_n low mid-sequence: immediate return to reset values. A partial INTA is discarded.
//  New requests arriving during the sequence are held in the IRR by the freeze and are
//   re-evaluated in IDLE.
// STRUCTURE
//  pic_pkg: FSM state enum, SPURIOUS_LVL=3'd7, NUM_IRQ_MAX=8, function rot_idx(idx,ptr).
//  Sub-module pic_prio_resolver: combinational rotating priority encoder over
//   (cand, isr, ptr) -> win_vld, win_lvl, isr_top. It is reused by the EOI path for
//   isr_top. The FSM, synchronizer and ISR/pointer registers stay in inta_sequencer.
// TESTING
//  1 irr=0x10, imr=0, base=0x08 -> int_o after 1 clk; INTA#1: irr_clr=0x10, isr=0x10,
//    freeze=1; INTA#2: vec_o=0x44.
//  2 irr=0x0A, isr=0 -> IR1 wins, vec low bits=1. With isr=0x01 and irr=0x04: int_o stays
//    low (nested block).
//  3 irr drops to 0 between fall and ACK1 -> spurious: vec_o low bits=7, isr unchanged,
//    irr_clr=0.
//  4 aeoi=1, rot_aeoi=1, service IR3 -> isr=0 after INTA#2, ptr=3; next irr=0x18 -> IR4
//    wins.
//  5 isr=0x05, non-specific EOI -> isr=0x04; specific EOI lvl=2 -> isr=0; EOI with empty
//    ISR -> no change.
//  6 assert rst_n in WAIT2 -> all outputs 0 asynchronously, FSM IDLE, vec_oe_o low.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt-acknowledge path.
package pic_pkg;

    localparam int         NUM_IRQ_MAX  = 8;
    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK1,
        S_WAIT1,
        S_WAIT2,
        S_ACK2
    } pic_state_e;

    // Rank of a level under rotation: 0 is the slot right after ptr (highest priority).
    function automatic logic [2:0] rot_idx(input logic [2:0] idx, input logic [2:0] ptr,
                                           input int n);
        return 3'((int'(idx) + 2 * n - int'(ptr) - 1) % n);
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: picks the top candidate and the top in-service level,
// and qualifies the candidate against the in-service level (fully nested mode).
module pic_prio_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]         cand_i,
    input  logic [NUM_IRQ-1:0]         isr_i,
    input  logic [$clog2(NUM_IRQ)-1:0] ptr_i,
    output logic                       win_vld_o,
    output logic [$clog2(NUM_IRQ)-1:0] win_lvl_o,
    output logic [$clog2(NUM_IRQ)-1:0] isr_top_o
);

    localparam int IW = $clog2(NUM_IRQ);

    logic          w_cand_hit;
    logic          w_isr_hit;
    logic [IW-1:0] w_cand_lvl;
    logic [IW-1:0] w_isr_lvl;
    logic [IW-1:0] w_idx;
    logic [2:0]    w_cand_rank;
    logic [2:0]    w_isr_rank;

    // Walk from lowest to highest rank so the last hit is the top-priority one.
    always_comb begin
        w_cand_hit = 1'b0;
        w_isr_hit  = 1'b0;
        w_cand_lvl = '0;
        w_isr_lvl  = '0;
        w_idx      = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            w_idx = ptr_i + IW'(k + 1);
            if (cand_i[w_idx]) begin
                w_cand_hit = 1'b1;
                w_cand_lvl = w_idx;
            end
            if (isr_i[w_idx]) begin
                w_isr_hit = 1'b1;
                w_isr_lvl = w_idx;
            end
        end
    end

    assign w_cand_rank = rot_idx(3'(w_cand_lvl), 3'(ptr_i), NUM_IRQ);
    assign w_isr_rank  = rot_idx(3'(w_isr_lvl), 3'(ptr_i), NUM_IRQ);

    assign win_vld_o = w_cand_hit && (!w_isr_hit || (w_cand_rank < w_isr_rank));
    assign win_lvl_o = w_cand_lvl;
    assign isr_top_o = w_isr_lvl;

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge controller: raises INT, walks the two-pulse INTA handshake,
// owns the ISR and the rotation pointer, and services EOI commands.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int NUM_IRQ  = 8,
    parameter int SYNC_STG = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irr_i,
    input  logic [NUM_IRQ-1:0] imr_i,
    input  logic [4:0]         vec_base_i,
    input  logic               aeoi_i,
    input  logic               rot_aeoi_i,
    input  logic               eoi_vld_i,
    input  logic               eoi_spec_i,
    input  logic               eoi_rot_i,
    input  logic [2:0]         eoi_lvl_i,
    input  logic               inta_n_i,
    output logic               int_o,
    output logic               inta_freeze_o,
    output logic [NUM_IRQ-1:0] irr_clr_o,
    output logic [NUM_IRQ-1:0] isr_o,
    output logic [7:0]         vec_o,
    output logic               vec_oe_o
);

    localparam int IW = $clog2(NUM_IRQ);

    pic_state_e         r_state;
    pic_state_e         w_state_nxt;
    logic [SYNC_STG:0]  r_sync;
    logic               w_fall;
    logic               w_rise;
    logic               w_win_vld;
    logic [IW-1:0]      w_win_lvl;
    logic [IW-1:0]      w_isr_top;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      w_ptr_nxt;
    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] w_isr_set;
    logic [NUM_IRQ-1:0] w_isr_clr;
    logic [NUM_IRQ-1:0] r_clr;
    logic [2:0]         r_lvl;
    logic               r_spur;
    logic               r_int;
    logic               r_frz;
    logic               r_voe;

    // Idles high so reset never manufactures an INTA edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STG-1:0], inta_n_i};
    end

    assign w_fall = r_sync[SYNC_STG] & ~r_sync[SYNC_STG-1];
    assign w_rise = ~r_sync[SYNC_STG] & r_sync[SYNC_STG-1];

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .cand_i    (irr_i & ~imr_i),
        .isr_i     (r_isr),
        .ptr_i     (r_ptr),
        .win_vld_o (w_win_vld),
        .win_lvl_o (w_win_lvl),
        .isr_top_o (w_isr_top)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win_vld) w_state_nxt = S_REQ;
            S_REQ:   if (w_fall)    w_state_nxt = S_ACK1;
            S_ACK1:                 w_state_nxt = S_WAIT1;
            S_WAIT1: if (w_rise)    w_state_nxt = S_WAIT2;
            S_WAIT2: if (w_fall)    w_state_nxt = S_ACK2;
            S_ACK2:  if (w_rise)    w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Set mask is OR-ed after the clear mask, so an ACK1 set beats an EOI on the same bit.
    always_comb begin
        w_isr_set = '0;
        w_isr_clr = '0;
        w_ptr_nxt = r_ptr;
        if (r_state == S_ACK1 && w_win_vld)
            w_isr_set[w_win_lvl] = 1'b1;
        if (r_state == S_ACK2 && w_rise && aeoi_i && !r_spur) begin
            w_isr_clr[r_lvl[IW-1:0]] = 1'b1;
            if (rot_aeoi_i) w_ptr_nxt = r_lvl[IW-1:0];
        end
        if (eoi_vld_i && |r_isr) begin
            if (eoi_spec_i) begin
                w_isr_clr[eoi_lvl_i[IW-1:0]] = 1'b1;
                if (eoi_rot_i) w_ptr_nxt = eoi_lvl_i[IW-1:0];
            end else begin
                w_isr_clr[w_isr_top] = 1'b1;
                if (eoi_rot_i) w_ptr_nxt = w_isr_top;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= IW'(NUM_IRQ - 1);
            r_isr   <= '0;
            r_clr   <= '0;
            r_lvl   <= '0;
            r_spur  <= 1'b0;
            r_int   <= 1'b0;
            r_frz   <= 1'b0;
            r_voe   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_isr   <= (r_isr & ~w_isr_clr) | w_isr_set;
            r_clr   <= '0;
            case (r_state)
                S_IDLE:  if (w_win_vld) r_int <= 1'b1;
                S_REQ:   if (w_fall)    r_frz <= 1'b1;
                S_ACK1: begin
                    // No winner left by now: answer with the spurious IR7 vector.
                    r_int  <= 1'b0;
                    r_spur <= !w_win_vld;
                    r_lvl  <= w_win_vld ? 3'(w_win_lvl) : SPURIOUS_LVL;
                    r_clr  <= w_isr_set;
                end
                S_WAIT2: if (w_fall) r_voe <= 1'b1;
                S_ACK2: begin
                    if (w_rise) begin
                        r_voe <= 1'b0;
                        r_frz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign int_o         = r_int;
    assign inta_freeze_o = r_frz;
    assign irr_clr_o     = r_clr;
    assign isr_o         = r_isr;
    assign vec_oe_o      = r_voe;
    assign vec_o         = r_voe ? {vec_base_i, r_lvl} : 8'h00;

endmodule
